// File: rtl/atp_note_validator.sv
// atp_note_validator: banknote measurement and classification stage of the ATP cash path.
//
// A note is measured while it passes the acceptor sensor. The stage records its length in clock
// cycles and its peak width, detects tears (the sensor drops out mid-note) and jams, and emits a
// one-cycle classification result.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-low
//   accept_en     1 = a new note may start; a note already in progress always completes
//   note_present  optical sensor, 1 while paper is under it
//   note_width    width sensor reading, meaningful while note_present = 1
//   jam_clear     operator clear, acted on only while jammed and the path is empty
//   cashmethod    denomination code; 3'b111 = no note
//   invalid       rejected note (strobe cycle) or jammed
//   note_strobe   one-cycle pulse marking a valid result
//   jam           1 while jammed
//   accepted_cnt / rejected_cnt  saturating result counters (only with ATP_NOTE_STATS_EN)
//
// Build option: define ATP_NOTE_STATS_EN to add the two saturating 16-bit statistics counters.
module atp_note_validator #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned L10     = 120,
  parameter int unsigned L20     = 130,
  parameter int unsigned L50     = 140,
  parameter int unsigned L100    = 150,
  parameter int unsigned L200    = 160,
  parameter int unsigned L500    = 170,
  parameter int unsigned TOL     = 3,
  parameter int unsigned W_MIN   = 40,
  parameter int unsigned W_MAX   = 60,
  parameter int unsigned GAP_MAX = 4,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_en,
  input  logic        note_present,
  input  logic [7:0]  note_width,
  input  logic        jam_clear,
  output logic [2:0]  cashmethod,
  output logic        invalid,
  output logic        note_strobe,
  output logic        jam
`ifdef ATP_NOTE_STATS_EN
  ,
  output logic [15:0] accepted_cnt,
  output logic [15:0] rejected_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle, StMeasure, StGap, StDecide, StOutput, StJam, StIgnore
  } state_e;

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] GapMax = CNT_W'(GAP_MAX);
  localparam logic [7:0]       WMin   = 8'(W_MIN);
  localparam logic [7:0]       WMax   = 8'(W_MAX);
  localparam int unsigned      Nom [6] = '{L10, L20, L50, L100, L200, L500};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, gap_q, gap_d;
  logic [7:0]       wmax_q, wmax_d;
  logic             torn_q, torn_d;
  logic [2:0]       code_q, code_d;
  logic             rej_q, rej_d;

  logic [CNT_W-1:0] len_inc;
  logic [2:0]       match_code;
  logic             match_found;

  // Distance is taken in CNT_W + 1 bits so the subtraction cannot wrap.
  function automatic logic within_tol(input logic [CNT_W-1:0] len, input int unsigned nom);
    logic [CNT_W:0] a, b, d;
    a = {1'b0, len};
    b = (CNT_W+1)'(nom);
    d = (a >= b) ? (a - b) : (b - a);
    return d <= (CNT_W+1)'(TOL);
  endfunction

  // Lowest denomination within tolerance wins, hence the descending scan.
  always_comb begin
    match_found = 1'b0;
    match_code  = 3'b111;
    for (int i = 5; i >= 0; i--) begin
      if (within_tol(len_q, Nom[i])) begin
        match_found = 1'b1;
        match_code  = 3'(i);
      end
    end
  end

  assign len_inc = len_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    wmax_d      = wmax_q;
    torn_d      = torn_q;
    code_d      = code_q;
    rej_d       = rej_q;
    cashmethod  = 3'b111;
    invalid     = 1'b0;
    note_strobe = 1'b0;
    jam         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (note_present) begin
          if (accept_en) begin
            state_d = StMeasure;
            len_d   = CNT_W'(1);
            wmax_d  = note_width;
            torn_d  = 1'b0;
          end else begin
            state_d = StIgnore;
            gap_d   = '0;
          end
        end
      end
      StMeasure: begin
        if (note_present) begin
          len_d = len_inc;
          if (note_width > wmax_q) wmax_d = note_width;
          if (len_inc == MaxLen) state_d = StJam;
        end else begin
          state_d = StGap;
          gap_d   = CNT_W'(1);
        end
      end
      StGap: begin
        if (note_present) begin
          // Paper returned after a dropout: the note is torn, keep measuring.
          torn_d  = 1'b1;
          len_d   = len_inc;
          if (note_width > wmax_q) wmax_d = note_width;
          state_d = (len_inc == MaxLen) ? StJam : StMeasure;
        end else if (gap_q >= GapMax) begin
          state_d = StDecide;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDecide: begin
        code_d  = match_code;
        rej_d   = torn_q | ~match_found | (wmax_q < WMin) | (wmax_q > WMax);
        state_d = StOutput;
      end
      StOutput: begin
        note_strobe = 1'b1;
        invalid     = rej_q;
        cashmethod  = rej_q ? 3'b111 : code_q;
        state_d     = StIdle;
      end
      StJam: begin
        jam     = 1'b1;
        invalid = 1'b1;
        if (jam_clear && !note_present) state_d = StIdle;
      end
      StIgnore: begin
        // Note arrived while acceptance was off: skip it until the path stays empty.
        if (note_present) begin
          gap_d = '0;
        end else if (gap_q >= GapMax) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      gap_q   <= '0;
      wmax_q  <= '0;
      torn_q  <= 1'b0;
      code_q  <= 3'b111;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      wmax_q  <= wmax_d;
      torn_q  <= torn_d;
      code_q  <= code_d;
      rej_q   <= rej_d;
    end
  end

`ifdef ATP_NOTE_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d, rej_cnt_q, rej_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (state_q == StOutput) begin
      if (rej_q) begin
        if (rej_cnt_q != 16'hFFFF) rej_cnt_d = rej_cnt_q + 16'd1;
      end else begin
        if (acc_cnt_q != 16'hFFFF) acc_cnt_d = acc_cnt_q + 16'd1;
      end
    end
    // A jam entry counts as a rejected note.
    if (state_q != StJam && state_d == StJam && rej_cnt_q != 16'hFFFF) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign accepted_cnt = acc_cnt_q;
  assign rejected_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_atp_note_validator.sv
// Self-checking bench for atp_note_validator.
module tb_atp_note_validator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       accept_en = 1'b0;
  logic       note_present = 1'b0;
  logic [7:0] note_width = 8'd0;
  logic       jam_clear = 1'b0;
  logic [2:0] cashmethod;
  logic       invalid, note_strobe, jam;
`ifdef ATP_NOTE_STATS_EN
  logic [15:0] accepted_cnt, rejected_cnt;
`endif

  atp_note_validator dut (
    .clk          (clk),
    .reset        (reset),
    .accept_en    (accept_en),
    .note_present (note_present),
    .note_width   (note_width),
    .jam_clear    (jam_clear),
    .cashmethod   (cashmethod),
    .invalid      (invalid),
    .note_strobe  (note_strobe),
    .jam          (jam)
`ifdef ATP_NOTE_STATS_EN
    ,
    .accepted_cnt (accepted_cnt),
    .rejected_cnt (rejected_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         peak;
    bit         torn;
    logic [2:0] cm;
    bit         inv;
  } vec_t;

  typedef struct {
    logic [2:0] cm;
    logic       inv;
  } res_t;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_acc = 0;
  int   exp_rej = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one note (len high samples, optional 2-cycle dropout at mid-note), then watches
  // 20 cycles of empty path for the result strobe and scores it against the queue.
  task automatic run_note(input int len, input int peak, input bit torn, input bit en_at_start,
                          input bit expect_strobe, input string name);
    int   strobes = 0;
    int   lat = -1;
    bit   idle_ok = 1'b1;
    res_t r;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (note_strobe || invalid || cashmethod !== 3'b111 || jam) idle_ok = 1'b0;
      if (i == 0) accept_en = en_at_start;
      if (!en_at_start && i == 10) accept_en = 1'b1;
      if (torn && i == len / 2) begin
        note_present = 1'b0;
        repeat (2) @(negedge clk);
      end
      note_present = 1'b1;
      note_width   = (i == len / 2) ? 8'(peak) : 8'(peak - 2);
    end
    @(negedge clk);
    note_present = 1'b0;
    note_width   = 8'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (note_strobe) begin
        strobes++;
        lat = c;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s unexpected strobe: got cashmethod %0d, required no strobe", name,
                   cashmethod);
        end else begin
          r = sb.pop_front();
          check({name, " cashmethod"}, int'(cashmethod), int'(r.cm));
          check({name, " invalid"}, int'(invalid), int'(r.inv));
        end
      end else if (invalid || cashmethod !== 3'b111 || jam) begin
        idle_ok = 1'b0;
      end
    end
    check({name, " strobe count"}, strobes, expect_strobe ? 1 : 0);
    if (expect_strobe) check({name, " latency"}, lat, 6);
    check({name, " idle outputs"}, int'(idle_ok), 1);
  endtask

  vec_t vecs[14];

  initial begin
    int  strobes;
    bit  early_jam;

    vecs = '{
      '{150, 50, 1'b0, 3'b011, 1'b0},
      '{173, 50, 1'b0, 3'b101, 1'b0},
      '{174, 50, 1'b0, 3'b111, 1'b1},
      '{120, 50, 1'b1, 3'b111, 1'b1},
      '{140, 61, 1'b0, 3'b111, 1'b1},
      '{140, 60, 1'b0, 3'b010, 1'b0},
      '{140, 40, 1'b0, 3'b010, 1'b0},
      '{140, 39, 1'b0, 3'b111, 1'b1},
      '{117, 50, 1'b0, 3'b000, 1'b0},
      '{116, 50, 1'b0, 3'b111, 1'b1},
      '{133, 50, 1'b0, 3'b001, 1'b0},
      '{125, 50, 1'b0, 3'b111, 1'b1},
      '{160, 50, 1'b0, 3'b100, 1'b0},
      '{254, 50, 1'b0, 3'b111, 1'b1}
    };

    // Reset state
    repeat (3) @(negedge clk);
    check("reset cashmethod", int'(cashmethod), 7);
    check("reset invalid", int'(invalid), 0);
    check("reset strobe", int'(note_strobe), 0);
    check("reset jam", int'(jam), 0);
`ifdef ATP_NOTE_STATS_EN
    check("reset accepted_cnt", int'(accepted_cnt), 0);
    check("reset rejected_cnt", int'(rejected_cnt), 0);
`endif
    reset     = 1'b1;
    accept_en = 1'b1;

    // Table-driven notes
    for (int k = 0; k < 14; k++) begin
      sb.push_back('{vecs[k].cm, vecs[k].inv});
      if (vecs[k].inv) exp_rej++;
      else exp_acc++;
      run_note(vecs[k].len, vecs[k].peak, vecs[k].torn, 1'b1, 1'b1, $sformatf("vec%0d", k));
    end

    // Note that starts while acceptance is off stays ignored even if enabled mid-note
    run_note(150, 50, 1'b0, 1'b0, 1'b0, "ignored note");

    // Jam after 255 high samples
    early_jam = 1'b0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (jam || note_strobe) early_jam = 1'b1;
      note_present = 1'b1;
      note_width   = 8'd50;
    end
    exp_rej++;
    @(negedge clk);
    check("jam not early", int'(early_jam), 0);
    check("jam asserted", int'(jam), 1);
    check("jam invalid", int'(invalid), 1);
    check("jam cashmethod", int'(cashmethod), 7);
    check("jam no strobe", int'(note_strobe), 0);
    jam_clear = 1'b1;
    @(negedge clk);
    check("jam_clear with paper ignored", int'(jam), 1);
    jam_clear    = 1'b0;
    note_present = 1'b0;
    @(negedge clk);
    check("jam holds without clear", int'(jam), 1);
    jam_clear = 1'b1;
    @(negedge clk);
    jam_clear = 1'b0;
    check("jam cleared", int'(jam), 0);
    check("jam cleared invalid", int'(invalid), 0);
    repeat (5) @(negedge clk);

    // Reset mid-note drops the note
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      note_present = 1'b1;
      note_width   = 8'd50;
    end
    @(negedge clk);
    reset        = 1'b0;
    note_present = 1'b0;
    @(negedge clk);
    check("mid-note reset cashmethod", int'(cashmethod), 7);
    check("mid-note reset invalid", int'(invalid), 0);
    check("mid-note reset jam", int'(jam), 0);
`ifdef ATP_NOTE_STATS_EN
    check("mid-note reset accepted_cnt", int'(accepted_cnt), 0);
    check("mid-note reset rejected_cnt", int'(rejected_cnt), 0);
    exp_acc = 0;
    exp_rej = 0;
`endif
    reset   = 1'b1;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (note_strobe) strobes++;
    end
    check("mid-note reset no strobe", strobes, 0);

`ifdef ATP_NOTE_STATS_EN
    // Post-reset statistics: 3 accepted, 2 rejected, 1 ignored
    sb.push_back('{3'b011, 1'b0}); exp_acc++;
    run_note(150, 50, 1'b0, 1'b1, 1'b1, "stats a1");
    sb.push_back('{3'b111, 1'b1}); exp_rej++;
    run_note(174, 50, 1'b0, 1'b1, 1'b1, "stats r1");
    sb.push_back('{3'b000, 1'b0}); exp_acc++;
    run_note(120, 50, 1'b0, 1'b1, 1'b1, "stats a2");
    sb.push_back('{3'b111, 1'b1}); exp_rej++;
    run_note(140, 61, 1'b0, 1'b1, 1'b1, "stats r2");
    sb.push_back('{3'b101, 1'b0}); exp_acc++;
    run_note(170, 50, 1'b0, 1'b1, 1'b1, "stats a3");
    run_note(150, 50, 1'b0, 1'b0, 1'b0, "stats ignored");
    check("accepted_cnt", int'(accepted_cnt), exp_acc);
    check("rejected_cnt", int'(rejected_cnt), exp_rej);
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
